// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the multicycle MIPS controller and its datapath.
// The controller uses the master modport and the datapath uses the slave modport.
interface mips_multicycle_ctrl_if #(
    parameter int unsigned STATE_W = 4
);
    logic [5:0]         opcode;
    logic               zero;
    logic               mem_ready;
    logic               stall;
    logic               mem_read;
    logic               mem_write;
    logic               i_or_d;
    logic               ir_write;
    logic               pc_write;
    logic               pc_write_cond;
    logic [1:0]         pc_source;
    logic [1:0]         alu_op;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic               reg_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               illegal_op;
    logic               mem_timeout;
    logic [STATE_W-1:0] state;

    modport master (
        input  opcode, zero, mem_ready, stall,
        output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, pc_source,
               alu_op, alu_src_a, alu_src_b, reg_write, reg_dst, mem_to_reg, illegal_op,
               mem_timeout, state
    );

    modport slave (
        output opcode, zero, mem_ready, stall,
        input  mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, pc_source,
               alu_op, alu_src_a, alu_src_b, reg_write, reg_dst, mem_to_reg, illegal_op,
               mem_timeout, state
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main controller: sequences memory, IR, PC, ALU and register file.
// Handles memory-ready waits with an optional timeout, stalls and illegal opcodes.
module mips_multicycle_ctrl #(
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned STATE_W      = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    mips_multicycle_ctrl_if.master bus
);
    localparam int unsigned CNT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRExec   = 4'd6,
        StRWb     = 4'd7,
        StIExec   = 4'd8,
        StIWb     = 4'd9,
        StBranch  = 4'd10,
        StJump    = 4'd11
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q;
    logic               mem_timeout_q;
    logic               mem_wait;
    logic               timeout_hit;

    assign mem_wait    = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
    assign timeout_hit = (MEM_WAIT_MAX != 0) && mem_wait && !bus.mem_ready && !bus.stall &&
                         (wait_cnt_q == CNT_W'(MEM_WAIT_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StFetch;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_timeout_q <= mem_timeout_q | timeout_hit;
            if ((state_d != state_q) || timeout_hit) begin
                wait_cnt_q <= '0;
            end else if (mem_wait && !bus.mem_ready && !bus.stall &&
                         (wait_cnt_q != CNT_W'(MEM_WAIT_MAX))) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.ir_write      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.pc_source     = 2'b00;
        bus.alu_op        = 2'b00;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.illegal_op    = 1'b0;

        case (state_q)
            StFetch: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    state_d      = StDecode;
                end
            end
            StDecode: begin
                bus.alu_src_b = 2'b11;
                case (bus.opcode)
                    6'b100011, 6'b101011: state_d = StMemAddr;
                    6'b000000:            state_d = StRExec;
                    6'b001000:            state_d = StIExec;
                    6'b000100:            state_d = StBranch;
                    6'b000010:            state_d = StJump;
                    default: begin
                        bus.illegal_op = 1'b1;
                        state_d        = StFetch;
                    end
                endcase
            end
            StMemAddr: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = (bus.opcode == 6'b100011) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
                if (bus.mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                state_d        = StFetch;
            end
            StMemWr: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
                if (bus.mem_ready) state_d = StFetch;
            end
            StRExec: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
                state_d       = StRWb;
            end
            StRWb: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
                state_d       = StFetch;
            end
            StIExec: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = StIWb;
            end
            StIWb: begin
                bus.reg_write = 1'b1;
                state_d       = StFetch;
            end
            StBranch: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = 2'b01;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = 2'b01;
                state_d           = StFetch;
            end
            StJump: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = 2'b10;
                state_d       = StFetch;
            end
            default: state_d = StFetch;
        endcase

        if (timeout_hit) state_d = StFetch;

        // Stall freezes the state; request lines follow the held state so they stay up.
        if (bus.stall) begin
            state_d           = state_q;
            bus.ir_write      = 1'b0;
            bus.pc_write      = 1'b0;
            bus.pc_write_cond = 1'b0;
            bus.reg_write     = 1'b0;
            bus.illegal_op    = 1'b0;
        end

        // FETCH drives mem_read combinationally, so outputs are masked while in reset.
        if (!rst_n) begin
            bus.mem_read  = 1'b0;
            bus.alu_src_b = 2'b00;
            bus.ir_write  = 1'b0;
            bus.pc_write  = 1'b0;
        end
    end

    assign bus.mem_timeout = mem_timeout_q;
    assign bus.state       = STATE_W'(state_q);
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multicycle main controller for the MIPS core: a Moore/Mealy FSM that sequences the shared ALU, the unified instruction/data memory, the IR, the PC and the register file over several cycles per instruction.
- Decodes LW, SW, ADDI, BEQ, J and R-type.
- Waits on a memory ready handshake.
- Flags illegal opcodes.
- Sits between the IR opcode field and the datapath mux/enable inputs.

Parameters:
- MEM_WAIT_MAX, 15, maximum cycles spent waiting for mem_ready in one access before timeout; 0 disables the timeout.
- STATE_W, 4, width of the debug state output.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- opcode  in  6  IR[31:26], valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- stall  in  1  hold the FSM in its current state; no enables asserted
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  IR load enable
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if zero
- pc_source  out  2  PC mux: 00 = ALU, 01 = ALUOut, 10 = jump target
- alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded
- alu_src_a  out  1  0 = PC, 1 = A register
- alu_src_b  out  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- reg_write  out  1  register file write enable
- reg_dst  out  1  write register select: 0 = rt, 1 = rd
- mem_to_reg  out  1  write-back source: 0 = ALUOut, 1 = MDR
- illegal_op  out  1  one-cycle pulse on an undefined opcode
- mem_timeout  out  1  sticky flag, set when a memory wait exceeds MEM_WAIT_MAX
- state  out  STATE_W  current state encoding, for debug

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - State goes to FETCH and the wait counter clears.
  - All outputs are 0, except that state reads the FETCH encoding.
  - Reset asserted in the middle of any multi-cycle access abandons it; no write-enable may be seen high after the reset edge.
- State encodings:
  - FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_RD = 3, MEM_WB = 4, MEM_WR = 5, R_EXEC = 6, R_WB = 7, I_EXEC = 8, I_WB = 9, BRANCH = 10, JUMP = 11.
- FETCH:
  - Drives mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
  - ir_write and pc_write are asserted only in a cycle where mem_ready = 1 (Mealy).
  - On mem_ready the FSM moves to DECODE; otherwise it stays in FETCH.
- DECODE:
  - Drives alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target precompute).
  - Next state by opcode:
    - 100011 (LW) and 101011 (SW) go to MEM_ADDR.
    - 000000 (R-type) goes to R_EXEC.
    - 001000 (ADDI) goes to I_EXEC.
    - 000100 (BEQ) goes to BRANCH.
    - 000010 (J) goes to JUMP.
    - Any other opcode pulses illegal_op for this cycle and returns to FETCH.
- MEM_ADDR:
  - Drives alu_src_a = 1, alu_src_b = 10, alu_op = 00.
  - Goes to MEM_RD for LW, MEM_WR for SW.
- MEM_RD:
  - Drives mem_read = 1, i_or_d = 1.
  - Waits for mem_ready, then goes to MEM_WB.
- MEM_WB:
  - Drives reg_write = 1, reg_dst = 0, mem_to_reg = 1.
  - Goes to FETCH.
- MEM_WR:
  - Drives mem_write = 1, i_or_d = 1.
  - Waits for mem_ready, then goes to FETCH.
- R_EXEC:
  - Drives alu_src_a = 1, alu_src_b = 00, alu_op = 10.
  - Goes to R_WB.
- R_WB:
  - Drives reg_write = 1, reg_dst = 1, mem_to_reg = 0.
  - Goes to FETCH.
- I_EXEC:
  - Drives alu_src_a = 1, alu_src_b = 10, alu_op = 00.
  - Goes to I_WB.
- I_WB:
  - Drives reg_write = 1, reg_dst = 0, mem_to_reg = 0.
  - Goes to FETCH.
- BRANCH:
  - Drives alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01.
  - Goes to FETCH.
- JUMP:
  - Drives pc_write = 1, pc_source = 10.
  - Goes to FETCH.
- Outputs not listed for a state are 0.
- Cycle counts with zero wait states:
  - LW = 5
  - SW = 4
  - R-type = 4
  - ADDI = 4
  - BEQ = 3
  - J = 3
- Each memory wait cycle adds 1.
- Stall:
  - When stall = 1, the state holds.
  - ir_write, pc_write, pc_write_cond, reg_write and illegal_op are forced to 0.
  - mem_read and mem_write hold their current value, so an outstanding request is not dropped.
  - mem_ready arriving during a stall is ignored; the memory holds it asserted until the FSM advances.
- Memory wait counter:
  - Increments each cycle the FSM is in FETCH, MEM_RD or MEM_WR with mem_ready = 0 and stall = 0.
  - Saturates at MEM_WAIT_MAX.
  - Clears when the state changes.
- Timeout (MEM_WAIT_MAX ≠ 0):
  - Triggers when the counter equals MEM_WAIT_MAX and mem_ready is still 0.
  - mem_timeout sets and stays set until reset.
  - The FSM aborts to FETCH without asserting any write-enable.

Test Plan:
- Reset held for 3 cycles, then released with mem_ready tied to 1 → state 0→1→2→3→4→0 for opcode 100011; reg_write = 1 and mem_to_reg = 1 only in state 4; 5 cycles total.
- R-type 000000 with mem_ready held low for 2 FETCH cycles → ir_write and pc_write pulse exactly once, in the 3rd FETCH cycle; reg_dst = 1 and reg_write = 1 in R_WB; total 6 cycles.
- BEQ with zero = 1, then BEQ with zero = 0 → pc_write_cond = 1, alu_op = 01 and pc_source = 01 in BRANCH in both cases; pc_write stays 0 throughout BRANCH.
- Opcode 111111 → illegal_op is high for exactly one cycle in DECODE, next state is FETCH, and no reg_write or mem_write is seen.
- SW in MEM_WR with stall = 1 for 3 cycles while mem_ready = 1 → state held at 5 and mem_write held at 1; after stall drops, advances to FETCH on the next edge.
- MEM_WAIT_MAX = 4, LW with mem_ready never asserted in MEM_RD → mem_timeout rises after 4 wait cycles, FSM returns to FETCH, reg_write stays 0; mid-test rst_n low clears mem_timeout immediately (asynchronously).
